disbus_master: RTL and testbench

- Hardware serial initiator for the two-wire display bus (disclk/disdat) that feeds the u3090mg display responder.
- Takes a byte stream on a valid/ready interface and emits a framed write transaction: START, bytes MSB first with a 9th ACK clock per byte, then STOP.
- Write-only. No read transfers.
- Replaces port bit-banging so firmware-free test benches and future system glue can drive the display controller directly.

---
 rtl/disbus_master_if.sv | 33 +++
 rtl/disbus_master.sv | 217 +++++++++++++++++++++
 tb/tb_disbus_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/disbus_master_if.sv
// disbus_master_if
//   Groups the byte-stream handshake, the two-wire bus lines and the
//   transaction status of disbus_master into one bundle.
//
//   s_data/s_valid/s_last/s_ready : byte stream into the initiator
//   scl/sda_out                   : bus lines driven by the initiator (1 = released)
//   sda_in                        : wired-AND data line as seen at the pin
//   busy/done/nack                : transaction status
//
//   master : the initiator's view (disbus_master)
//   slave  : the view of whatever feeds bytes in and models the bus
interface disbus_master_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       scl;
    logic       sda_out;
    logic       sda_in;
    logic       busy;
    logic       done;
    logic       nack;

    modport master (
        input  s_data, s_valid, s_last, sda_in,
        output s_ready, scl, sda_out, busy, done, nack
    );

    modport slave (
        output s_data, s_valid, s_last, sda_in,
        input  s_ready, scl, sda_out, busy, done, nack
    );
endinterface

// File: rtl/disbus_master.sv
// disbus_master
//   Write-only serial initiator for the two-wire display bus. Takes bytes
//   from a valid/ready stream and frames them as START, 8 data bits MSB
//   first plus an ACK clock per byte, then STOP.
//
//   Parameters
//     CLK_DIV : clk cycles per bus phase (half an SCL period), 2..65535
//
//   Ports
//     clk   : system clock
//     reset : asynchronous, active-high reset; releases both lines at once
//     bus   : disbus_master_if.master
//               s_data/s_valid/s_last in, s_ready out (combinational)
//               scl/sda_out out (registered), sda_in in
//               busy/done/nack out (registered); nack valid with done
module disbus_master #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic            clk,
    input  logic            reset,
    disbus_master_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_A,
        S_START_B,
        S_BIT_LO,
        S_BIT_HI,
        S_ACK_LO,
        S_ACK_HI,
        S_WAIT,
        S_STOP_A,
        S_STOP_B,
        S_STOP_C,
        S_DRAIN
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        last;
    logic        nack_flag;
    logic        scl_q;
    logic        sda_q;
    logic        busy_q;
    logic        done_q;
    logic        nack_q;
    logic        phase_end;

    assign phase_end = (cnt == LAST_CNT);

    // Bytes are taken only where the bus is parked: idle, clock-stretched
    // between bytes, or discarding the rest of a NACKed transfer.
    assign bus.s_ready = (state == S_IDLE) || (state == S_WAIT) || (state == S_DRAIN);

    assign bus.scl     = scl_q;
    assign bus.sda_out = sda_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.nack    = nack_q;

    // Line levels are registered together with the state, so each
    // transition sets the levels of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shift     <= '0;
            bit_idx   <= '0;
            last      <= 1'b0;
            nack_flag <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.s_valid) begin
                        shift  <= bus.s_data;
                        last   <= bus.s_last;
                        cnt    <= '0;
                        state  <= S_START_A;
                        scl_q  <= 1'b1;
                        sda_q  <= 1'b0;      // START: SDA falls with SCL high
                        busy_q <= 1'b1;
                    end
                end

                // SCL held low for as long as the next byte is late.
                S_WAIT: begin
                    if (bus.s_valid) begin
                        shift   <= bus.s_data;
                        last    <= bus.s_last;
                        bit_idx <= 3'd7;
                        cnt     <= '0;
                        state   <= S_BIT_LO;
                        scl_q   <= 1'b0;
                        sda_q   <= bus.s_data[7];
                    end
                end

                // Bus already stopped; swallow bytes up to the end of the
                // transfer so the upstream stream stays in step.
                S_DRAIN: begin
                    if (bus.s_valid && bus.s_last) begin
                        state     <= S_IDLE;
                        done_q    <= 1'b1;
                        nack_q    <= 1'b1;
                        nack_flag <= 1'b0;
                        busy_q    <= 1'b0;
                        scl_q     <= 1'b1;
                        sda_q     <= 1'b1;
                    end
                end

                // Every remaining state lasts exactly one timed phase.
                default: begin
                    if (!phase_end) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        case (state)
                            S_START_A: begin
                                state <= S_START_B;
                                scl_q <= 1'b0;
                                sda_q <= 1'b0;
                            end
                            S_START_B: begin
                                state   <= S_BIT_LO;
                                bit_idx <= 3'd7;
                                scl_q   <= 1'b0;
                                sda_q   <= shift[7];
                            end
                            S_BIT_LO: begin
                                state <= S_BIT_HI;
                                scl_q <= 1'b1;
                                sda_q <= shift[7];
                            end
                            S_BIT_HI: begin
                                scl_q <= 1'b0;
                                if (bit_idx == 3'd0) begin
                                    state <= S_ACK_LO;
                                    sda_q <= 1'b1;   // release for responder ACK
                                end else begin
                                    shift   <= {shift[6:0], 1'b0};
                                    bit_idx <= bit_idx - 3'd1;
                                    state   <= S_BIT_LO;
                                    sda_q   <= shift[6];
                                end
                            end
                            S_ACK_LO: begin
                                state <= S_ACK_HI;
                                scl_q <= 1'b1;
                                sda_q <= 1'b1;
                            end
                            // ACK sampled on the last cycle of the high phase,
                            // when the responder has had the longest to settle.
                            S_ACK_HI: begin
                                scl_q <= 1'b0;
                                if (bus.sda_in) begin
                                    nack_flag <= 1'b1;
                                    state     <= S_STOP_A;
                                    sda_q     <= 1'b0;
                                end else if (last) begin
                                    state <= S_STOP_A;
                                    sda_q <= 1'b0;
                                end else begin
                                    state <= S_WAIT;
                                    sda_q <= 1'b1;
                                end
                            end
                            S_STOP_A: begin
                                state <= S_STOP_B;
                                scl_q <= 1'b1;
                                sda_q <= 1'b0;
                            end
                            S_STOP_B: begin
                                state <= S_STOP_C;
                                scl_q <= 1'b1;
                                sda_q <= 1'b1;       // STOP: SDA rises with SCL high
                            end
                            S_STOP_C: begin
                                scl_q <= 1'b1;
                                sda_q <= 1'b1;
                                // A NACK always stops immediately, so `last`
                                // still belongs to the NACKed byte here.
                                if (nack_flag && !last) begin
                                    state <= S_DRAIN;
                                end else begin
                                    state     <= S_IDLE;
                                    done_q    <= 1'b1;
                                    nack_q    <= nack_flag;
                                    nack_flag <= 1'b0;
                                    busy_q    <= 1'b0;
                                end
                            end
                            default: begin
                                state  <= S_IDLE;
                                scl_q  <= 1'b1;
                                sda_q  <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disbus_master.sv
// tb_disbus_master
//   Directed bench for disbus_master with CLK_DIV=4. A negedge monitor
//   counts START/STOP conditions and records SDA at every SCL rise.
module tb_disbus_master;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    logic sda_pull;   // responder pulls SDA low (ACK) when set

    always #5 clk = ~clk;

    disbus_master_if bus();
    assign bus.sda_in = bus.sda_out & ~sda_pull;

    disbus_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor
    logic mon_vld = 1'b0;
    logic p_scl, p_sda;
    int   starts = 0, stops = 0, rises = 0;
    logic rise_sda [0:1023];
    int   rise_cyc [0:1023];

    always @(negedge clk) begin
        if (reset) begin
            mon_vld <= 1'b0;
        end else begin
            mon_vld <= 1'b1;
            p_scl   <= bus.scl;
            p_sda   <= bus.sda_out;
            if (mon_vld) begin
                if (p_scl && bus.scl && p_sda && !bus.sda_out) starts <= starts + 1;
                if (p_scl && bus.scl && !p_sda && bus.sda_out) stops <= stops + 1;
                if (!p_scl && bus.scl) begin
                    rise_sda[rises[9:0]] <= bus.sda_out;
                    rise_cyc[rises[9:0]] <= cyc;
                    rises <= rises + 1;
                end
            end
        end
    end

    function automatic logic [7:0] rx_byte(input int base);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[7-k] = rise_sda[(base + k) % 1024];
        return b;
    endfunction

    // Feeds up to three bytes; gap>0 holds s_valid low for gap cycles once
    // the block is stretching the clock after byte 0. lat = cycles from the
    // first accept edge to the edge that raised done; -1 on timeout.
    task automatic run_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input int gap, output int lat, output logic done_at_accept);
        logic [7:0] bs [3];
        int acc, t;
        logic ok;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        lat = -1; done_at_accept = 1'b0; acc = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 1 && gap > 0) begin
                bus.s_valid = 1'b0;
                t = 0;
                while (!(bus.s_ready && bus.busy) && t < 1000) begin @(negedge clk); t++; end
                if (t >= 1000) begin
                    total++; bad++; $display("FAIL wait_entry: timed out, want WAIT state");
                    return;
                end
                ok = 1'b1;
                for (int k = 0; k < gap; k++) begin
                    if (bus.scl !== 1'b0 || bus.sda_out !== 1'b1) ok = 1'b0;
                    @(negedge clk);
                end
                total++;
                if (ok !== 1'b1) begin bad++; $display("FAIL wait_hold: lines moved during stall, want scl=0 sda=1"); end
            end
            bus.s_data  = bs[i];
            bus.s_last  = (i == n - 1);
            bus.s_valid = 1'b1;
            t = 0;
            while (!bus.s_ready && t < 1000) begin @(negedge clk); t++; end
            if (!bus.s_ready) begin
                total++; bad++; $display("FAIL accept_%0d: s_ready never rose", i);
                bus.s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == 0) acc = cyc;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (bus.done) done_at_accept = 1'b1;
        t = 0;
        while (!bus.done && t < 2000) begin @(negedge clk); t++; end
        if (!bus.done) begin
            total++; bad++; $display("FAIL done_wait: done never pulsed");
        end else begin
            lat = cyc - acc;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.scl !== 1'b1)     begin bad++; $display("FAIL rst_scl: got %b want 1", bus.scl); end
        total++; if (bus.sda_out !== 1'b1) begin bad++; $display("FAIL rst_sda: got %b want 1", bus.sda_out); end
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        total++; if (bus.nack !== 1'b0)    begin bad++; $display("FAIL rst_nack: got %b want 0", bus.nack); end
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.s_ready); end
    endtask

    task automatic test_single();
        int s0, p0, r0, lat;
        logic da;
        sda_pull = 1'b1;
        s0 = starts; p0 = stops; r0 = rises;
        run_xfer(8'h5A, 8'h00, 8'h00, 1, 0, lat, da);
        // START 2 + byte 18 + STOP 3 phases of 4 cycles
        total++; if (lat !== 92)       begin bad++; $display("FAIL single_lat: got %0d want 92", lat); end
        total++; if (bus.nack !== 1'b0) begin bad++; $display("FAIL single_nack: got %b want 0", bus.nack); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", bus.done); end
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d want 1", starts - s0); end
        total++; if (stops - p0 !== 1)  begin bad++; $display("FAIL single_stops: got %0d want 1", stops - p0); end
        total++; if (rises - r0 !== 10) begin bad++; $display("FAIL single_rises: got %0d want 10", rises - r0); end
        total++; if (rx_byte(r0) !== 8'h5A) begin bad++; $display("FAIL single_bits: got %h want 5a", rx_byte(r0)); end
        total++; if (rise_sda[r0 + 8] !== 1'b1) begin bad++; $display("FAIL single_ack_release: got %b want 1", rise_sda[r0 + 8]); end
        total++; if (rise_cyc[r0 + 1] - rise_cyc[r0] !== 8) begin bad++; $display("FAIL single_scl_period: got %0d want 8", rise_cyc[r0 + 1] - rise_cyc[r0]); end
    endtask

    task automatic test_back_to_back(input int gap);
        int s0, p0, r0, lat, want;
        logic da;
        sda_pull = 1'b1;
        s0 = starts; p0 = stops; r0 = rises;
        run_xfer(8'h98, 8'h01, 8'hFF, 3, gap, lat, da);
        // (2 + 54 + 3) phases * 4 + one WAIT cycle per byte boundary + stall
        want = 59 * 4 + 2 + gap;
        total++; if (lat !== want)      begin bad++; $display("FAIL b2b_lat(gap %0d): got %0d want %0d", gap, lat, want); end
        total++; if (bus.nack !== 1'b0) begin bad++; $display("FAIL b2b_nack(gap %0d): got %b want 0", gap, bus.nack); end
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL b2b_starts(gap %0d): got %0d want 1", gap, starts - s0); end
        total++; if (stops - p0 !== 1)  begin bad++; $display("FAIL b2b_stops(gap %0d): got %0d want 1", gap, stops - p0); end
        total++; if (rises - r0 !== 28) begin bad++; $display("FAIL b2b_rises(gap %0d): got %0d want 28", gap, rises - r0); end
        total++; if ({rx_byte(r0), rx_byte(r0 + 9), rx_byte(r0 + 18)} !== 24'h9801FF) begin
            bad++; $display("FAIL b2b_bytes(gap %0d): got %h want 9801ff", gap, {rx_byte(r0), rx_byte(r0 + 9), rx_byte(r0 + 18)});
        end
    endtask

    task automatic test_nack();
        int s0, p0, r0, lat;
        logic da;
        sda_pull = 1'b0;
        s0 = starts; p0 = stops; r0 = rises;
        run_xfer(8'h3C, 8'h11, 8'h22, 3, 0, lat, da);
        // byte 0 + STOP ends at 92, DRAIN takes the next two bytes back to back
        total++; if (lat !== 94)        begin bad++; $display("FAIL nack_lat: got %0d want 94", lat); end
        total++; if (da !== 1'b1)       begin bad++; $display("FAIL nack_done_on_accept: got %b want 1", da); end
        total++; if (bus.nack !== 1'b1) begin bad++; $display("FAIL nack_flag: got %b want 1", bus.nack); end
        total++; if (rises - r0 !== 10) begin bad++; $display("FAIL nack_rises: got %0d want 10", rises - r0); end
        total++; if (stops - p0 !== 1)  begin bad++; $display("FAIL nack_stops: got %0d want 1", stops - p0); end
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL nack_starts: got %0d want 1", starts - s0); end
        repeat (5) @(negedge clk);
        total++; if (bus.nack !== 1'b1) begin bad++; $display("FAIL nack_hold: got %b want 1", bus.nack); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nack_done_once: got %b want 0", bus.done); end
        sda_pull = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r0, s0, t, lat;
        logic ok, da;
        sda_pull = 1'b1;
        r0 = rises;
        bus.s_data = 8'hA5; bus.s_last = 1'b1; bus.s_valid = 1'b1;
        t = 0;
        while (!bus.s_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        // fifth SCL rise is the high phase of bit 3
        t = 0;
        while (rises < r0 + 5 && t < 500) begin @(negedge clk); t++; end
        #1;
        total++; if ({bus.scl, bus.sda_out} !== 2'b10) begin bad++; $display("FAIL mid_pre: got %b want 10", {bus.scl, bus.sda_out}); end
        reset = 1'b1;
        #1;
        total++; if (bus.scl !== 1'b1)     begin bad++; $display("FAIL mid_scl: got %b want 1", bus.scl); end
        total++; if (bus.sda_out !== 1'b1) begin bad++; $display("FAIL mid_sda: got %b want 1", bus.sda_out); end
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_quiet: done/busy rose after reset"); end
        s0 = starts; r0 = rises;
        run_xfer(8'hA5, 8'h00, 8'h00, 1, 0, lat, da);
        total++; if (starts - s0 !== 1)     begin bad++; $display("FAIL mid_restart: got %0d starts want 1", starts - s0); end
        total++; if (lat !== 92)            begin bad++; $display("FAIL mid_lat: got %0d want 92", lat); end
        total++; if (rx_byte(r0) !== 8'hA5) begin bad++; $display("FAIL mid_bits: got %h want a5", rx_byte(r0)); end
        total++; if (bus.nack !== 1'b0)     begin bad++; $display("FAIL mid_nack: got %b want 0", bus.nack); end
    endtask

    initial begin
        reset       = 1'b1;
        sda_pull    = 1'b1;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back(0);
        test_back_to_back(100);
        test_nack();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
